// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core.
// Instruction width, NOP encoding, reset vector and decode field slices.
package mips_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/inst_mem.sv
// Word-addressed instruction memory.
// Combinational read, synchronous write, zero (NOP) at time zero.
module inst_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH] = '{default: NOP_INST};

    // Reads see the pre-write word in the cycle of a same-index write.
    assign rdata = mem[raddr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// Fetch stage: PC, instruction memory and the IF/ID register.
// Priority at each edge: reset, redirect (flush), stall, fetch.
module inst_fetch_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter int          IMEM_AW    = 6,
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic [31:0]        pc,
    output logic [31:0]        dinstOut,
    output logic [31:0]        dpc4,
    output logic               dvalid
);

    logic [31:0] pc4;
    logic [31:0] target;
    logic [31:0] fetched;

    assign pc4    = pc + 32'd4;
    assign target = redirect_pc & ~32'h3;

    inst_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IMEM_AW)
    ) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc[IMEM_AW+1:2]),
        .rdata (fetched)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            dinstOut <= NOP_INST;
            dpc4     <= '0;
            dvalid   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= target;
            dinstOut <= NOP_INST;
            dpc4     <= '0;
            dvalid   <= 1'b0;
        end else if (!stall) begin
            pc       <= pc4;
            dinstOut <= fetched;
            dpc4     <= pc4;
            dvalid   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage.
// Reference model pushes expected outputs; a monitor pops and compares.
module tb_inst_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] pc;
    logic [31:0] dinstOut;
    logic [31:0] dpc4;
    logic        dvalid;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        v;
    } exp_t;

    exp_t q[$];

    logic [31:0] m_mem [64];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_v;

    inst_fetch_stage #(
        .IMEM_DEPTH (64),
        .IMEM_AW    (6),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .dinstOut       (dinstOut),
        .dpc4           (dpc4),
        .dvalid         (dvalid)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: the DUT presents a new IF/ID state after every edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_inst", dinstOut, e.inst);
            chk("sb_dpc4", dpc4, e.pc4);
            chk("sb_dvalid", {31'b0, dvalid}, {31'b0, e.v});
        end
    end

    task automatic step(input logic rst, input logic stl, input logic rv,
                        input logic [31:0] rpc, input logic we,
                        input logic [5:0] wa, input logic [31:0] wd);
        exp_t e;
        @(negedge clock);
        reset = rst;
        stall = stl;
        redirect_valid = rv;
        redirect_pc = rpc;
        imem_we = we;
        imem_waddr = wa;
        imem_wdata = wd;
        if (rst) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
        end else if (rv) begin
            m_pc = (rpc / 4) * 4;
            m_inst = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
        end else if (!stl) begin
            m_inst = m_mem[(m_pc / 4) % 64];
            m_pc4 = m_pc + 4;
            m_v = 1'b1;
            m_pc = m_pc + 4;
        end
        if (we) m_mem[wa] = wd;
        e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.v = m_v;
        q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
        m_pc = 0; m_inst = 0; m_pc4 = 0; m_v = 0;

        step(1, 0, 0, 0, 1, 6'd0, 32'h2001_0005);
        step(1, 0, 0, 0, 1, 6'd1, 32'h2002_0007);
        step(1, 0, 0, 0, 1, 6'd2, 32'h0022_1820);
        step(1, 0, 0, 0, 1, 6'd3, 32'hAC03_0000);
        step(1, 0, 0, 0, 1, 6'd63, 32'h1234_5678);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, dvalid}, 32'h0);

        run(1);
        chk("f0_inst", dinstOut, 32'h2001_0005);
        chk("f0_dpc4", dpc4, 32'h4);
        chk("f0_valid", {31'b0, dvalid}, 32'h1);
        run(1);
        chk("f1_inst", dinstOut, 32'h2002_0007);

        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("stall_inst", dinstOut, 32'h2002_0007);
        chk("stall_dpc4", dpc4, 32'h8);
        chk("stall_pc", pc, 32'h8);
        run(1);
        chk("post_stall", dinstOut, 32'h0022_1820);
        run(1);
        chk("f3_inst", dinstOut, 32'hAC03_0000);
        chk("f3_dpc4", dpc4, 32'h10);

        step(0, 1, 1, 32'h0000_0013, 0, 0, 0);
        chk("redir_pc", pc, 32'h10);
        chk("redir_inst", dinstOut, 32'h0);
        chk("redir_valid", {31'b0, dvalid}, 32'h0);
        run(1);
        chk("tgt_dpc4", dpc4, 32'h14);
        chk("tgt_inst", dinstOut, 32'h0);

        step(0, 0, 1, 32'h0000_000C, 0, 0, 0);
        chk("pre_rst_pc", pc, 32'hC);
        step(1, 1, 1, 32'h0000_0020, 0, 0, 0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_dpc4", dpc4, 32'h0);
        run(1);
        chk("mem_kept", dinstOut, 32'h2001_0005);

        run(1);
        step(0, 0, 0, 0, 1, 6'd2, 32'hDEAD_BEEF);
        chk("rbw_old", dinstOut, 32'h0022_1820);
        step(0, 0, 1, 32'h0000_0008, 0, 0, 0);
        run(1);
        chk("rbw_new", dinstOut, 32'hDEAD_BEEF);

        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        run(1);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_dpc4", dpc4, 32'h0);
        chk("wrap_inst", dinstOut, 32'h1234_5678);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom,
                 $urandom_range(0, 3) == 0,
                 6'($urandom_range(0, 63)),
                 $urandom);
        end

        @(posedge clock);
        #3;
        chk("queue_drained", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
